mem_copy_engine: RTL and testbench

- Bus-master stage that sits directly upstream of the 256x8 RAM block and drives its address/data/wr/cs pins.
- Copies a block of bytes from a source region to a destination region of the same RAM.
- Reads the RAM's combinational output and writes the byte back on the following clock edge.
- Controlled by a start/busy/done handshake from the surrounding control logic.

---
 rtl/mem_copy_engine.sv | 138 +++++++++++++
 tb/tb_mem_copy_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// ============================================================================
// Module   : mem_copy_engine
// Purpose  : Byte-by-byte block copy master for a single-port 256x8 RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0] mem_o,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wr,
  output logic                  mem_cs,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bytes_left
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] C_ZERO = '0;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] src_ptr_q;
  logic [ADDR_WIDTH-1:0] dst_ptr_q;
  logic [ADDR_WIDTH-1:0] bytes_left_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  mem_wr_q;
  logic                  mem_cs_q;
  logic                  busy_q;
  logic                  done_q;

  logic [ADDR_WIDTH-1:0] src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_d;
  logic [ADDR_WIDTH-1:0] bytes_left_d;

  // Pointers wrap naturally modulo 2^ADDR_WIDTH.
  assign src_ptr_d    = src_ptr_q + C_ONE;
  assign dst_ptr_d    = dst_ptr_q + C_ONE;
  assign bytes_left_d = bytes_left_q - C_ONE;

  // Every output is loaded on the edge that enters the state it belongs to,
  // so the RAM pins are pure register outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      src_ptr_q     <= '0;
      dst_ptr_q     <= '0;
      bytes_left_q  <= '0;
      mem_address_q <= '0;
      data_q        <= '0;
      mem_wr_q      <= 1'b0;
      mem_cs_q      <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            bytes_left_q <= length;
            if (length != C_ZERO) begin
              state_q       <= S_READ;
              src_ptr_q     <= src_addr;
              dst_ptr_q     <= dst_addr;
              mem_address_q <= src_addr;
              mem_cs_q      <= 1'b0;
              mem_wr_q      <= 1'b0;
              busy_q        <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_q       <= S_WRITE;
          data_q        <= mem_o;
          src_ptr_q     <= src_ptr_d;
          mem_address_q <= dst_ptr_q;
          mem_wr_q      <= 1'b1;
        end
        S_WRITE: begin
          dst_ptr_q    <= dst_ptr_d;
          bytes_left_q <= bytes_left_d;
          mem_wr_q     <= 1'b0;
          if (bytes_left_q == C_ONE) begin
            state_q  <= S_DONE;
            mem_cs_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            state_q       <= S_READ;
            mem_address_q <= src_ptr_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_cs_q <= 1'b1;
          mem_wr_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data    = data_q;
  assign mem_wr      = mem_wr_q;
  assign mem_cs      = mem_cs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign bytes_left  = bytes_left_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// Module   : tb_mem_copy_engine
// Purpose  : Scoreboard bench for mem_copy_engine against a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_addr, dst_addr, length;
  logic [7:0] mem_o, mem_address, mem_data, bytes_left;
  logic       mem_wr, mem_cs, busy, done;

  logic [7:0]  ram   [256];
  logic [7:0]  model [256];
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  int          n_vec = 0;
  int          n_err = 0;

  mem_copy_engine #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .mem_o       (mem_o),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wr      (mem_wr),
    .mem_cs      (mem_cs),
    .busy        (busy),
    .done        (done),
    .bytes_left  (bytes_left)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: combinational read, write on the rising edge.
  assign mem_o = ram[mem_address];
  always @(posedge clock) begin
    if (mem_cs === 1'b0 && mem_wr === 1'b1) ram[mem_address] = mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each observed RAM write is matched against the oldest expected write.
  always @(negedge clock) begin
    if (reset === 1'b0 && mem_cs === 1'b0 && mem_wr === 1'b1) begin
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_address), 32'(mon_e[15:8]));
        chk("wr_data", 32'(mem_data), 32'(mon_e[7:0]));
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    ram[a]   = v;
    model[a] = v;
  endtask

  task automatic plan_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    logic [7:0] a, b;
    a = s;
    b = d;
    for (int i = 0; i < int'(l); i++) begin
      model[b] = model[a];
      exp_q.push_back({b, model[b]});
      a = a + 8'd1;
      b = b + 8'd1;
    end
  endtask

  task automatic check_ram();
    for (int i = 0; i < 256; i++)
      chk($sformatf("ram[%02h]", i), 32'(ram[i]), 32'(model[i]));
  endtask

  // Runs one copy and checks the cycle-by-cycle handshake; rc>0 pulses a
  // competing start with addresses (rs, rd) during cycle rc.
  task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                         input int rc, input logic [7:0] rs, input logic [7:0] rd);
    int n, ncyc, bl;
    logic act;
    n    = int'(l);
    ncyc = (n == 0) ? 1 : 2 * n + 1;
    plan_copy(s, d, l);
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    src_addr = ~s;
    dst_addr = ~d;
    length   = l + 8'd3;
    for (int c = 1; c <= ncyc + 1; c++) begin
      act = (c <= 2 * n);
      bl  = act ? n - (c - 1) / 2 : 0;
      chk("busy",       32'(busy),       32'(act));
      chk("done",       32'(done),       32'(c == ncyc));
      chk("mem_cs",     32'(mem_cs),     32'(!act));
      chk("mem_wr",     32'(mem_wr),     32'(act && (c % 2 == 0)));
      chk("bytes_left", 32'(bytes_left), 32'(bl));
      if (c == rc) begin
        start    = 1'b1;
        src_addr = rs;
        dst_addr = rd;
        length   = 8'd2;
      end
      @(posedge clock); #1;
      start = 1'b0;
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    check_ram();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) preload(8'(i), 8'(i) ^ 8'h5C);
    reset    = 1'b0;
    start    = 1'b0;
    src_addr = 8'h00;
    dst_addr = 8'h00;
    length   = 8'h00;
    #1 reset = 1'b1;
    #1;
    chk("rst_cs",   32'(mem_cs),      32'd1);
    chk("rst_wr",   32'(mem_wr),      32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_data", 32'(mem_data),    32'd0);
    chk("rst_busy", 32'(busy),        32'd0);
    chk("rst_done", 32'(done),        32'd0);
    chk("rst_bl",   32'(bytes_left),  32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // Basic four-byte copy
    preload(8'h10, 8'hAA); preload(8'h11, 8'hBB);
    preload(8'h12, 8'hCC); preload(8'h13, 8'hDD);
    do_copy(8'h10, 8'h80, 8'd4, 0, 8'h00, 8'h00);

    // Zero length: immediate done, no RAM access
    do_copy(8'h00, 8'h40, 8'd0, 0, 8'h00, 8'h00);

    // Address wrap through 0xFF -> 0x00
    preload(8'hFE, 8'h11); preload(8'hFF, 8'h22); preload(8'h00, 8'h33);
    do_copy(8'hFE, 8'h20, 8'd3, 0, 8'h00, 8'h00);

    // Overlapping forward copy fills the region
    preload(8'h30, 8'h5A); preload(8'h31, 8'h00);
    preload(8'h32, 8'h00); preload(8'h33, 8'h00);
    do_copy(8'h30, 8'h31, 8'd3, 0, 8'h00, 8'h00);

    // Start pulsed mid-copy is ignored
    do_copy(8'h10, 8'h90, 8'd4, 3, 8'h50, 8'h60);

    // Reset during the second WRITE
    preload(8'h80, 8'h01); preload(8'h81, 8'h02);
    preload(8'h82, 8'h03); preload(8'h83, 8'h04);
    model[8'h80] = model[8'h10];
    exp_q.push_back({8'h80, model[8'h10]});
    src_addr = 8'h10;
    dst_addr = 8'h80;
    length   = 8'd4;
    start    = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("pre_rst_wr", 32'(mem_wr), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_cs",   32'(mem_cs),     32'd1);
    chk("mid_rst_wr",   32'(mem_wr),     32'd0);
    chk("mid_rst_busy", 32'(busy),       32'd0);
    chk("mid_rst_done", 32'(done),       32'd0);
    chk("mid_rst_bl",   32'(bytes_left), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    check_ram();
    do_copy(8'h10, 8'h80, 8'd4, 0, 8'h00, 8'h00);

    // Maximum length with wrap and overlap
    do_copy(8'hF0, 8'h00, 8'd255, 0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
